// File: rtl/chip8_fetch.sv
`default_nettype none
// ============================================================================
// Module   : chip8_fetch
// Brief    : CHIP-8 instruction fetch: owns the PC, reads two bytes big-endian
//            from byte-wide program memory and hands the opcode to the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module chip8_fetch #(
  parameter logic [11:0] RESET_PC    = 12'h200,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch,
  input  logic        pc_load,
  input  logic [11:0] pc_load_value,
  input  logic        skip,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [15:0] opcode,
  output logic        opcode_valid,
  output logic [11:0] pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_HI   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_RD_LO   = 3'd3,
    S_WAIT_LO = 3'd4
  } state_t;

  localparam logic [1:0] c_lat_last = 2'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_lat_cnt;
  logic        w_lat_last;
  logic        w_waiting;

  assign w_waiting  = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
  assign w_lat_last = (r_lat_cnt == c_lat_last);
  assign mem_rd     = (r_state == S_RD_HI) || (r_state == S_RD_LO);
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (fetch) w_next = S_RD_HI;
      S_RD_HI:   w_next = S_WAIT_HI;
      S_WAIT_HI: if (w_lat_last) w_next = S_RD_LO;
      S_RD_LO:   w_next = S_WAIT_LO;
      S_WAIT_LO: if (w_lat_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= 2'd0;
      pc           <= RESET_PC;
      opcode       <= 16'h0000;
      opcode_valid <= 1'b0;
      mem_addr     <= 12'h000;
    end else begin
      r_state      <= w_next;
      r_lat_cnt    <= (w_waiting && !w_lat_last) ? r_lat_cnt + 2'd1 : 2'd0;
      opcode_valid <= (r_state == S_WAIT_LO) && w_lat_last;
      // mem_addr is registered on entry to each read state so it stays put afterwards
      case (r_state)
        S_IDLE: begin
          if (fetch)        mem_addr <= pc;
          else if (pc_load) pc       <= pc_load_value;
          else if (skip)    pc       <= pc + 12'd2;
        end
        S_WAIT_HI: begin
          if (w_lat_last) begin
            opcode[15:8] <= mem_data;
            mem_addr     <= pc + 12'd1;
          end
        end
        S_WAIT_LO: begin
          if (w_lat_last) begin
            opcode[7:0] <= mem_data;
            pc          <= pc + 12'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip8_fetch
// Brief    : Randomized self-checking bench for chip8_fetch against a PC/memory
//            reference model, at MEM_LATENCY 1 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip8_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch, pc_load, skip;
  logic [11:0] pc_load_value;
  logic [11:0] mem_addr, pc;
  logic        mem_rd, opcode_valid, busy;
  logic [7:0]  mem_data;
  logic [15:0] opcode;

  logic        fetch_b;
  logic [11:0] mem_addr_b, pc_b;
  logic        mem_rd_b, opcode_valid_b, busy_b;
  logic [7:0]  mem_data_b;
  logic [15:0] opcode_b;

  logic [7:0]  mem [0:4095];
  logic [7:0]  garbage;
  logic        va;
  logic [11:0] aa;
  logic [1:0]  vb;
  logic [11:0] ab0, ab1;
  logic [11:0] rd_q [$];

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] model_pc;

  always #5 clk = ~clk;

  chip8_fetch #(.RESET_PC(12'h200), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .skip(skip), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .opcode(opcode),
    .opcode_valid(opcode_valid), .pc(pc), .busy(busy)
  );

  chip8_fetch #(.RESET_PC(12'h200), .MEM_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .fetch(fetch_b), .pc_load(1'b0),
    .pc_load_value(12'h000), .skip(1'b0), .mem_addr(mem_addr_b),
    .mem_rd(mem_rd_b), .mem_data(mem_data_b), .opcode(opcode_b),
    .opcode_valid(opcode_valid_b), .pc(pc_b), .busy(busy_b)
  );

  // Memory models: data is valid only in the window the latency promises
  always @(negedge clk) garbage <= 8'($urandom);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      va <= 1'b0;
      vb <= 2'b00;
    end else begin
      va  <= mem_rd;
      aa  <= mem_addr;
      vb  <= {vb[0], mem_rd_b};
      ab0 <= mem_addr_b;
      ab1 <= ab0;
    end
  end

  assign mem_data   = va    ? mem[aa]  : garbage;
  assign mem_data_b = vb[1] ? mem[ab1] : garbage;

  always @(posedge clk) if (!reset && mem_rd) rd_q.push_back(mem_addr);

  task automatic do_fetch(input string name, input logic with_load);
    logic [11:0] a0, a1;
    logic [15:0] exp_op;
    int n;
    a0 = model_pc;
    a1 = a0 + 12'd1;
    exp_op = {mem[a0], mem[a1]};
    rd_q.delete();
    @(negedge clk);
    fetch = 1'b1; pc_load = with_load; skip = with_load; pc_load_value = 12'h7AB;
    @(negedge clk);
    fetch = 1'b0; pc_load = 1'b0; skip = 1'b0;
    n = 0;
    while (!opcode_valid && n < 20) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL %s busy got=%b exp=1", name, busy); end
      end
    end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL %s latency got=%0d exp=4", name, n); end
    checks++;
    if (opcode !== exp_op) begin failures++; $display("FAIL %s opcode got=%h exp=%h", name, opcode, exp_op); end
    checks++;
    if (pc !== a0 + 12'd2) begin failures++; $display("FAIL %s pc got=%h exp=%h", name, pc, a0 + 12'd2); end
    checks++;
    if (rd_q.size() != 2 || rd_q[0] !== a0 || rd_q[1] !== a1) begin
      failures++;
      $display("FAIL %s rd_addrs got=%p exp=%h,%h", name, rd_q, a0, a1);
    end
    @(posedge clk); #1;
    checks++;
    if (opcode_valid !== 1'b0) begin failures++; $display("FAIL %s valid_pulse got=%b exp=0", name, opcode_valid); end
    model_pc = a0 + 12'd2;
  endtask

  task automatic do_load(input string name, input logic [11:0] v);
    @(negedge clk); pc_load = 1'b1; pc_load_value = v;
    @(negedge clk); pc_load = 1'b0;
    model_pc = v;
    checks++;
    if (pc !== model_pc) begin failures++; $display("FAIL %s pc got=%h exp=%h", name, pc, model_pc); end
  endtask

  task automatic do_skip(input string name);
    @(negedge clk); skip = 1'b1;
    @(negedge clk); skip = 1'b0;
    model_pc = model_pc + 12'd2;
    checks++;
    if (pc !== model_pc) begin failures++; $display("FAIL %s pc got=%h exp=%h", name, pc, model_pc); end
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch = 1'b0; pc_load = 1'b0; skip = 1'b0; pc_load_value = 12'h000; fetch_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pc !== 12'h200 || opcode !== 16'h0000 || opcode_valid !== 1'b0 || mem_rd !== 1'b0 ||
        mem_addr !== 12'h000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs got pc=%h op=%h v=%b rd=%b addr=%h busy=%b exp 200/0000/0/0/000/0",
               pc, opcode, opcode_valid, mem_rd, mem_addr, busy);
    end
    reset = 1'b0;
    model_pc = 12'h200;
  endtask

  task automatic test_basic();
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    do_fetch("basic", 1'b0);
  endtask

  task automatic test_skip_load();
    do_skip("skip");
    @(negedge clk); pc_load = 1'b1; skip = 1'b1; pc_load_value = 12'h300;
    @(negedge clk); pc_load = 1'b0; skip = 1'b0;
    model_pc = 12'h300;
    checks++;
    if (pc !== 12'h300) begin failures++; $display("FAIL load_over_skip pc got=%h exp=300", pc); end
    do_fetch("fetch_over_load", 1'b1);
  endtask

  task automatic test_wrap();
    do_load("wrap_load", 12'hFFF);
    mem[12'hFFF] = 8'hA2; mem[12'h000] = 8'hB4;
    do_fetch("wrap", 1'b0);
  endtask

  task automatic test_busy_ignore();
    logic [11:0] a0, a1;
    logic [15:0] exp_op;
    int pulses;
    a0 = model_pc; a1 = a0 + 12'd1;
    exp_op = {mem[a0], mem[a1]};
    @(negedge clk); fetch = 1'b1;
    @(negedge clk); pc_load = 1'b1; skip = 1'b1; pc_load_value = 12'h500;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_ignore busy got=%b exp=1", busy); end
    repeat (2) @(negedge clk);
    fetch = 1'b0; pc_load = 1'b0; skip = 1'b0;
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (opcode_valid) pulses++; end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL busy_ignore pulses got=%0d exp=1", pulses); end
    checks++;
    if (pc !== a0 + 12'd2) begin failures++; $display("FAIL busy_ignore pc got=%h exp=%h", pc, a0 + 12'd2); end
    checks++;
    if (opcode !== exp_op) begin failures++; $display("FAIL busy_ignore opcode got=%h exp=%h", opcode, exp_op); end
    model_pc = a0 + 12'd2;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0:       do_skip("rand_skip");
        1:       do_load("rand_load", 12'($urandom));
        default: do_fetch("rand_fetch", 1'($urandom));
      endcase
    end
  endtask

  task automatic test_reset_mid();
    do_load("pre_reset_load", 12'h456);
    mem[12'h456] = 8'hA5;
    @(negedge clk); fetch = 1'b1;
    @(negedge clk); fetch = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (pc !== 12'h200 || opcode !== 16'h0000 || opcode_valid !== 1'b0 || mem_rd !== 1'b0 ||
        mem_addr !== 12'h000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset outputs got pc=%h op=%h v=%b rd=%b addr=%h busy=%b exp 200/0000/0/0/000/0",
               pc, opcode, opcode_valid, mem_rd, mem_addr, busy);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    model_pc = 12'h200;
    do_fetch("post_reset", 1'b0);
  endtask

  task automatic test_latency2();
    int n;
    mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
    @(negedge clk); fetch_b = 1'b1;
    @(negedge clk); fetch_b = 1'b0;
    n = 0;
    while (!opcode_valid_b && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 6) begin failures++; $display("FAIL lat2 latency got=%0d exp=6", n); end
    checks++;
    if (opcode_b !== 16'h00E0) begin failures++; $display("FAIL lat2 opcode got=%h exp=00e0", opcode_b); end
    checks++;
    if (pc_b !== 12'h202) begin failures++; $display("FAIL lat2 pc got=%h exp=202", pc_b); end
    @(posedge clk); #1;
    checks++;
    if (opcode_valid_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL lat2 after valid=%b busy=%b exp 0/0", opcode_valid_b, busy_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_skip_load();
    test_wrap();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    test_latency2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
